direction_deque: RTL and testbench

//  Double-ended direction store for the maze solver datapath.
//  The search controller uses it in two ways:
//   - pushes one 2-bit move per step and pops the back to backtrack (LIFO);
//   - pops the front to replay the solved path from the start (FIFO).
//  It sits beside the X/Y position registers and feeds stack_out/is_deque_empty back to the controller.

---
 rtl/maze_pkg.sv | 17 +
 rtl/dir_ram.sv | 33 +++
 rtl/direction_deque.sv | 143 ++++++++++++++
 tb/tb_direction_deque.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze-solver definitions: direction encoding and maze size.
package maze_pkg;

   // 2-bit move codes that the search controller pushes per step
   typedef enum logic [1:0] {
      UP    = 2'b00,
      RIGHT = 2'b01,
      LEFT  = 2'b10,
      DOWN  = 2'b11
   } dir_t;

   // One deque entry per cell of a 16x16 maze
   localparam int unsigned MAZE_CELLS = 256;

   localparam int unsigned DIR_W = 2;

endpackage : maze_pkg

// File: rtl/dir_ram.sv
// Direction storage array: one synchronous write port, two asynchronous read ports.
// Read port A serves the front (head); read port B serves the back (tail-1).
module dir_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned DW    = 2,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output logic [DW-1:0] rdata_a_o,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_b_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Contents are never reset; the pointers decide what is valid
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Both reads are combinational so a pop can register the entry in one cycle
   always_comb begin
      rdata_a_o = mem_q[raddr_a_i];
      rdata_b_o = mem_q[raddr_b_i];
   end

endmodule : dir_ram

// File: rtl/direction_deque.sv
// Double-ended direction store for the maze solver datapath.
// Back end works as a stack for backtracking, front end as a queue for path replay.
// Optional feature: define DEQUE_LEVEL_EN to expose the occupancy count on port `level`.
module direction_deque
   import maze_pkg::*;
#(
   parameter int unsigned DEPTH = MAZE_CELLS,
   parameter int unsigned DW    = DIR_W,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop_back,
   input  logic          pop_front,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          is_empty,
   output logic          is_full,
   output logic          err
`ifdef DEQUE_LEVEL_EN
   ,
   output logic [AW:0]   level
`endif
);

   localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
   localparam logic [AW-1:0] PtrOne  = AW'(1);

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          dout_valid_q, dout_valid_d;
   logic          err_q, err_d;

   logic          sync_clr;
   logic          mem_we;
   logic [AW-1:0] back_addr;
   logic [DW-1:0] front_data;
   logic [DW-1:0] back_data;

   assign sync_clr = Rst | clr;

   // Back entry lives one below tail; AW-bit subtraction wraps 0 to DEPTH-1
   assign back_addr = tail_q - PtrOne;

   dir_ram #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_dir_ram (
      .clk_i     (Clk),
      .we_i      (mem_we),
      .waddr_i   (tail_q),
      .wdata_i   (din),
      .raddr_a_i (head_q),
      .rdata_a_o (front_data),
      .raddr_b_i (back_addr),
      .rdata_b_o (back_data)
   );

   // Arbitrate push > pop_back > pop_front and compute next pointer/count/output state
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      err_d        = err_q;
      mem_we       = 1'b0;

      if (push) begin
         // Any simultaneous pop loses arbitration and is flagged
         if (pop_back || pop_front) begin
            err_d = 1'b1;
         end
         if (count_q != FullCnt) begin
            mem_we  = ~sync_clr;
            tail_d  = tail_q + PtrOne;
            count_d = count_q + CntOne;
         end else begin
            err_d = 1'b1;
         end
      end else if (pop_back) begin
         if (pop_front) begin
            err_d = 1'b1;
         end
         if (count_q != '0) begin
            dout_d       = back_data;
            tail_d       = back_addr;
            count_d      = count_q - CntOne;
            dout_valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end else if (pop_front) begin
         if (count_q != '0) begin
            dout_d       = front_data;
            head_d       = head_q + PtrOne;
            count_d      = count_q - CntOne;
            dout_valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State registers; Rst and clr both clear and override any request that cycle
   always_ff @(posedge Clk) begin
      if (sync_clr) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         err_q        <= err_d;
      end
   end

   // Flags come straight from the registered count, so they show completed operations only
   always_comb begin
      dout       = dout_q;
      dout_valid = dout_valid_q;
      err        = err_q;
      is_empty   = (count_q == '0);
      is_full    = (count_q == FullCnt);
   end

`ifdef DEQUE_LEVEL_EN
   assign level = count_q;
`endif

endmodule : direction_deque

// File: tb/tb_direction_deque.sv
// Directed self-checking bench for direction_deque (default DEPTH=256, DW=2).
module tb_direction_deque;
   import maze_pkg::*;

   localparam int DEPTH = 256;

   logic       Clk;
   logic       Rst;
   logic       clr;
   logic       push;
   logic [1:0] din;
   logic       pop_back;
   logic       pop_front;
   logic [1:0] dout;
   logic       dout_valid;
   logic       is_empty;
   logic       is_full;
   logic       err;
`ifdef DEQUE_LEVEL_EN
   logic [8:0] level;
`endif

   int n_cmp;
   int n_bad;

   direction_deque dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .clr        (clr),
      .push       (push),
      .din        (din),
      .pop_back   (pop_back),
      .pop_front  (pop_front),
      .dout       (dout),
      .dout_valid (dout_valid),
      .is_empty   (is_empty),
      .is_full    (is_full),
      .err        (err)
`ifdef DEQUE_LEVEL_EN
      ,
      .level      (level)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Fill pattern used by the deep tests
   function automatic logic [1:0] pat(input int i);
      return 2'(i ^ (i >> 3));
   endfunction

   // Apply one cycle of requests; outputs are stable when this returns (#1 after the edge)
   task automatic step(input logic p, input logic [1:0] d, input logic pb, input logic pf,
                       input logic c);
      push      = p;
      din       = d;
      pop_back  = pb;
      pop_front = pf;
      clr       = c;
      @(posedge Clk);
      #1;
      push      = 1'b0;
      pop_back  = 1'b0;
      pop_front = 1'b0;
      clr       = 1'b0;
   endtask

   task automatic do_clr();
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      Rst = 1'b0;
      n_cmp++;
      if (is_empty !== 1'b1) begin
         n_bad++; $display("FAIL reset_is_empty got %b want 1", is_empty);
      end
      n_cmp++;
      if (is_full !== 1'b0) begin
         n_bad++; $display("FAIL reset_is_full got %b want 0", is_full);
      end
      n_cmp++;
      if (err !== 1'b0 || dout_valid !== 1'b0 || dout !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_outputs got err=%b dv=%b dout=%b want 0 0 00", err, dout_valid, dout);
      end
   endtask

   task automatic test_lifo();
      logic [1:0] exp [3];
      exp[0] = DOWN; exp[1] = RIGHT; exp[2] = UP;
      do_clr();
      step(1'b1, UP, 1'b0, 1'b0, 1'b0);
      step(1'b1, RIGHT, 1'b0, 1'b0, 1'b0);
      step(1'b1, DOWN, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (is_empty !== 1'b0 || dout_valid !== 1'b0) begin
         n_bad++; $display("FAIL lifo_after_push got empty=%b dv=%b want 0 0", is_empty, dout_valid);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (dout !== exp[k] || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL lifo_pop%0d got dout=%b dv=%b want %b 1", k, dout, dout_valid, exp[k]);
         end
      end
      n_cmp++;
      if (is_empty !== 1'b1 || err !== 1'b0) begin
         n_bad++; $display("FAIL lifo_end got empty=%b err=%b want 1 0", is_empty, err);
      end
   endtask

   task automatic test_fifo();
      logic [1:0] exp [3];
      exp[0] = UP; exp[1] = RIGHT; exp[2] = DOWN;
      do_clr();
      step(1'b1, UP, 1'b0, 1'b0, 1'b0);
      step(1'b1, RIGHT, 1'b0, 1'b0, 1'b0);
      step(1'b1, DOWN, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (dout !== exp[k] || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_pop%0d got dout=%b dv=%b want %b 1", k, dout, dout_valid, exp[k]);
         end
      end
      n_cmp++;
      if (is_empty !== 1'b1 || err !== 1'b0) begin
         n_bad++; $display("FAIL fifo_end got empty=%b err=%b want 1 0", is_empty, err);
      end
      // One idle cycle drops dout_valid but keeps dout
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (dout_valid !== 1'b0 || dout !== DOWN) begin
         n_bad++; $display("FAIL fifo_idle got dv=%b dout=%b want 0 11", dout_valid, dout);
      end
   endtask

   task automatic test_full();
      do_clr();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, pat(i), 1'b0, 1'b0, 1'b0);
         if (i == DEPTH - 2) begin
            n_cmp++;
            if (is_full !== 1'b0) begin
               n_bad++; $display("FAIL full_early got is_full=%b want 0", is_full);
            end
         end
      end
      n_cmp++;
      if (is_full !== 1'b1 || err !== 1'b0) begin
         n_bad++; $display("FAIL full_set got is_full=%b err=%b want 1 0", is_full, err);
      end
`ifdef DEQUE_LEVEL_EN
      n_cmp++;
      if (level !== 9'd256) begin
         n_bad++; $display("FAIL full_level got %0d want 256", level);
      end
`endif
      step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (is_full !== 1'b1 || err !== 1'b1) begin
         n_bad++; $display("FAIL full_overpush got is_full=%b err=%b want 1 1", is_full, err);
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (dout !== pat(i) || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL full_drain%0d got dout=%b dv=%b want %b 1", i, dout, dout_valid, pat(i));
         end
      end
      n_cmp++;
      if (is_empty !== 1'b1 || err !== 1'b1) begin
         n_bad++; $display("FAIL full_end got empty=%b err=%b want 1 1", is_empty, err);
      end
      do_clr();
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++; $display("FAIL clr_err got err=%b want 0", err);
      end
   endtask

   task automatic test_empty_pop();
      do_clr();
      step(1'b1, LEFT, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== LEFT || dout_valid !== 1'b1 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL empty_prep got dout=%b dv=%b err=%b want 10 1 0", dout, dout_valid, err);
      end
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== LEFT || dout_valid !== 1'b0 || err !== 1'b1 || is_empty !== 1'b1) begin
         n_bad++;
         $display("FAIL empty_pop_back got dout=%b dv=%b err=%b empty=%b want 10 0 1 1",
                  dout, dout_valid, err, is_empty);
      end
      do_clr();
      step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (dout_valid !== 1'b0 || err !== 1'b1 || dout !== 2'b00) begin
         n_bad++;
         $display("FAIL empty_pop_front got dv=%b err=%b dout=%b want 0 1 00", dout_valid, err, dout);
      end
   endtask

   task automatic test_wrap();
      do_clr();
      for (int i = 0; i < DEPTH; i++) step(1'b1, pat(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (dout !== pat(i)) begin
            n_bad++; $display("FAIL wrap_front%0d got %b want %b", i, dout, pat(i));
         end
      end
      step(1'b1, LEFT, 1'b0, 1'b0, 1'b0);
      step(1'b1, DOWN, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (is_full !== 1'b1) begin
         n_bad++; $display("FAIL wrap_refill got is_full=%b want 1", is_full);
      end
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== DOWN || dout_valid !== 1'b1) begin
         n_bad++; $display("FAIL wrap_back0 got dout=%b dv=%b want 11 1", dout, dout_valid);
      end
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== LEFT || dout_valid !== 1'b1) begin
         n_bad++; $display("FAIL wrap_back1 got dout=%b dv=%b want 10 1", dout, dout_valid);
      end
      for (int i = 2; i < DEPTH; i++) begin
         step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (dout !== pat(i) || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_replay%0d got dout=%b dv=%b want %b 1", i, dout, dout_valid, pat(i));
         end
      end
      n_cmp++;
      if (is_empty !== 1'b1 || err !== 1'b0) begin
         n_bad++; $display("FAIL wrap_end got empty=%b err=%b want 1 0", is_empty, err);
      end
   endtask

   // pop_back with tail at 0 must read slot DEPTH-1
   task automatic test_tail_wrap();
      do_clr();
      for (int i = 0; i < DEPTH; i++) step(1'b1, pat(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== pat(DEPTH - 1) || is_full !== 1'b0) begin
         n_bad++;
         $display("FAIL tail_wrap got dout=%b full=%b want %b 0", dout, is_full, pat(DEPTH - 1));
      end
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== pat(DEPTH - 2)) begin
         n_bad++; $display("FAIL tail_wrap2 got %b want %b", dout, pat(DEPTH - 2));
      end
   endtask

   task automatic test_contention();
      do_clr();
      step(1'b1, RIGHT, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (is_empty !== 1'b0 || err !== 1'b1 || dout_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL push_vs_pop got empty=%b err=%b dv=%b want 0 1 0", is_empty, err, dout_valid);
      end
      step(1'b1, DOWN, 1'b0, 1'b0, 1'b0);
      // Back beats front when both pops arrive together
      step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (dout !== DOWN || dout_valid !== 1'b1) begin
         n_bad++; $display("FAIL back_vs_front got dout=%b dv=%b want 11 1", dout, dout_valid);
      end
      step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (dout !== RIGHT || is_empty !== 1'b1) begin
         n_bad++; $display("FAIL contention_left got dout=%b empty=%b want 01 1", dout, is_empty);
      end
      step(1'b1, UP, 1'b0, 1'b0, 1'b0);
      step(1'b1, LEFT, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (is_empty !== 1'b1 || err !== 1'b0 || dout !== 2'b00) begin
         n_bad++;
         $display("FAIL clr_with_push got empty=%b err=%b dout=%b want 1 0 00", is_empty, err, dout);
      end
      // Rst likewise overrides a pop
      step(1'b1, UP, 1'b0, 1'b0, 1'b0);
      Rst = 1'b1;
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      Rst = 1'b0;
      n_cmp++;
      if (is_empty !== 1'b1 || dout_valid !== 1'b0) begin
         n_bad++; $display("FAIL rst_with_pop got empty=%b dv=%b want 1 0", is_empty, dout_valid);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      Rst       = 1'b0;
      clr       = 1'b0;
      push      = 1'b0;
      din       = 2'b00;
      pop_back  = 1'b0;
      pop_front = 1'b0;
      test_reset();
      test_lifo();
      test_fifo();
      test_full();
      test_empty_pop();
      test_wrap();
      test_tail_wrap();
      test_contention();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_direction_deque
